mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: icache and dcache share one RAM port.
// Dcache wins ties; a starvation counter lets icache preempt at word boundaries.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [2:0] SMAX       = 3'(STARVE_MAX);

    state_t     state_q, state_d;
    logic [2:0] scnt_q, scnt_d;
    logic       dreq;
    logic       access;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == RAM_ACCESS);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dreq)      state_d = DGRANT;
                else if (iREN) state_d = IGRANT;
            end
            DGRANT: begin
                if (!dreq)
                    state_d = iREN ? IGRANT : IDLE;
                else if (access && iREN && scnt_q >= SMAX)
                    state_d = IGRANT;
            end
            IGRANT: begin
                if (!iREN)
                    state_d = dreq ? DGRANT : IDLE;
                else if (access && dreq)
                    state_d = DGRANT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts only while icache waits behind a dcache owner.
    always_comb begin
        scnt_d = scnt_q;
        if (state_q == DGRANT && iREN)
            scnt_d = (scnt_q >= SMAX) ? SMAX : scnt_q + 3'd1;
        else if (state_q == IGRANT || !iREN)
            scnt_d = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        ramREN  = 1'b0;
        ramWEN  = 1'b0;
        ramaddr = iaddr;
        unique case (state_q)
            DGRANT: begin
                ramWEN  = dWEN;
                ramREN  = dREN & ~dWEN;
                ramaddr = daddr;
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            default: ;
        endcase
    end

    assign iwait    = ~(state_q == IGRANT && access);
    assign dwait    = ~(state_q == DGRANT && access);
    assign ramstore = dstore;
    assign iload    = ramload;
    assign dload    = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run
// checked against an ownership/counter reference model.
module tb_mem_arbiter;

    localparam int SM = 2;
    localparam int M_IDLE = 0;
    localparam int M_I = 1;
    localparam int M_D = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_bad = 0;
    int m_own = M_IDLE;
    int m_cnt = 0;

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // Advance the reference model across one rising edge.
    task automatic tick();
        int no, nc;
        bit dq, acc;
        dq  = dREN | dWEN;
        acc = (ramstate == 2'd2);
        nc  = m_cnt;
        if (m_own == M_D && iREN) nc = (m_cnt + 1 > SM) ? SM : m_cnt + 1;
        else if (m_own == M_I || !iREN) nc = 0;
        no = m_own;
        if (m_own == M_IDLE) begin
            if (dq) no = M_D;
            else if (iREN) no = M_I;
        end else if (m_own == M_D) begin
            if (!dq) no = iREN ? M_I : M_IDLE;
            else if (acc && iREN && m_cnt >= SM) no = M_I;
        end else begin
            if (!iREN) no = dq ? M_D : M_IDLE;
            else if (acc && dq) no = M_D;
        end
        @(posedge CLK);
        if (nRST) begin
            m_own = no;
            m_cnt = nc;
        end else begin
            m_own = M_IDLE;
            m_cnt = 0;
        end
        #1;
    endtask

    task automatic drain();
        iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        nRST = 0; iREN = 1; dREN = 1; dWEN = 0;
        iaddr = 32'h10; daddr = 32'h20; dstore = 0; ramload = 0;
        ramstate = 2'd2;
        #2;
        n_cmp++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            n_bad++;
            $display("FAIL reset_out: got %b want 0011",
                     {ramREN, ramWEN, iwait, dwait});
        end
        @(posedge CLK); #1;
        n_cmp++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            n_bad++;
            $display("FAIL reset_hold: got %b want 0011",
                     {ramREN, ramWEN, iwait, dwait});
        end
        iREN = 0; dREN = 0; ramstate = 2'd0;
        nRST = 1;
        m_own = M_IDLE; m_cnt = 0;
        #1;
        n_cmp++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            n_bad++;
            $display("FAIL reset_release: got %b want 0011",
                     {ramREN, ramWEN, iwait, dwait});
        end
        tick();
    endtask

    task automatic test_icache_read();
        int lows = 0;
        iREN = 1; iaddr = 32'h100; dREN = 0; dWEN = 0; ramstate = 2'd1;
        #1;
        n_cmp++;
        if (ramREN !== 1'b0) begin
            n_bad++;
            $display("FAIL icache_arb_cycle: ramREN got %b want 0", ramREN);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            ramstate = (k == 2) ? 2'd2 : 2'd1;
            ramload = $urandom;
            #1;
            n_cmp++;
            if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h100) begin
                n_bad++;
                $display("FAIL icache_strobe: got ren=%b wen=%b addr=%h want 1 0 100",
                         ramREN, ramWEN, ramaddr);
            end
            if (k == 2) begin
                n_cmp++;
                if (iload !== ramload) begin
                    n_bad++;
                    $display("FAIL icache_load: got %h want %h", iload, ramload);
                end
            end
            if (!iwait) lows++;
            tick();
        end
        n_cmp++;
        if (lows != 1) begin
            n_bad++;
            $display("FAIL icache_wait_pulses: got %0d want 1", lows);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        iREN = 1; dREN = 1; dWEN = 0;
        iaddr = 32'h300; daddr = 32'h200; ramstate = 2'd1;
        #1;
        tick();
        n_cmp++;
        if (ramaddr !== 32'h200 || {iwait, dwait} !== 2'b11) begin
            n_bad++;
            $display("FAIL simul_dgrant: got addr=%h waits=%b want 200 11",
                     ramaddr, {iwait, dwait});
        end
        tick();
        ramstate = 2'd2;
        #1;
        n_cmp++;
        if ({iwait, dwait} !== 2'b10) begin
            n_bad++;
            $display("FAIL simul_dcomplete: got waits=%b want 10", {iwait, dwait});
        end
        tick();
        dREN = 0; ramstate = 2'd0;
        #1;
        n_cmp++;
        if (iwait !== 1'b1 || ramREN !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_drop: got iwait=%b ren=%b want 1 0", iwait, ramREN);
        end
        tick();
        n_cmp++;
        if (ramaddr !== 32'h300 || ramREN !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_igrant: got addr=%h ren=%b want 300 1",
                     ramaddr, ramREN);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        iREN = 0; iaddr = 32'hdead0000;
        dWEN = 1; dREN = 0; daddr = 32'h400; ramstate = 2'd0;
        #1;
        tick();
        for (int w = 0; w < 4; w++) begin
            for (int ph = 0; ph < 2; ph++) begin
                dWEN = (w < 2); dREN = (w >= 2);
                daddr = 32'h400 + 32'(w * 4);
                dstore = $urandom;
                ramstate = (ph == 1) ? 2'd2 : 2'd1;
                #1;
                n_cmp++;
                if (ramaddr !== daddr || ramstore !== dstore) begin
                    n_bad++;
                    $display("FAIL burst_addr: got %h/%h want %h/%h",
                             ramaddr, ramstore, daddr, dstore);
                end
                n_cmp++;
                if ({ramWEN, ramREN} !== {w < 2, w >= 2}) begin
                    n_bad++;
                    $display("FAIL burst_strobe: got wen=%b ren=%b word %0d",
                             ramWEN, ramREN, w);
                end
                n_cmp++;
                if (dwait !== (ph == 0)) begin
                    n_bad++;
                    $display("FAIL burst_dwait: got %b want %b", dwait, ph == 0);
                end
                if (!dwait) pulses++;
                tick();
            end
        end
        n_cmp++;
        if (pulses != 4) begin
            n_bad++;
            $display("FAIL burst_pulses: got %0d want 4", pulses);
        end
        drain();
    endtask

    task automatic test_starvation();
        int dc = 0;
        int ic = 0;
        bit ret_chk = 0;
        logic [31:0] ea;
        iREN = 1; dREN = 1; dWEN = 0;
        iaddr = 32'h500; daddr = 32'h600; ramstate = 2'd0;
        #1;
        tick();
        for (int k = 0; k < 16; k++) begin
            ramstate = (k % 2 == 1) ? 2'd2 : 2'd1;
            #1;
            ea = (m_own == M_D) ? daddr : iaddr;
            n_cmp++;
            if (ramaddr !== ea) begin
                n_bad++;
                $display("FAIL starve_addr: cycle %0d got %h want %h", k, ramaddr, ea);
            end
            if (ret_chk) begin
                n_cmp++;
                if (ramaddr !== daddr) begin
                    n_bad++;
                    $display("FAIL starve_return: got %h want %h", ramaddr, daddr);
                end
            end
            if (!dwait) dc++;
            if (!iwait) begin
                ic++;
                if (ic == 1) begin
                    n_cmp++;
                    if (dc != SM) begin
                        n_bad++;
                        $display("FAIL starve_first: got %0d dcache done want %0d",
                                 dc, SM);
                    end
                end
            end
            ret_chk = !iwait;
            tick();
        end
        n_cmp++;
        if (dc != 6 || ic != 2) begin
            n_bad++;
            $display("FAIL starve_totals: got d=%0d i=%0d want 6 2", dc, ic);
        end
        drain();
    endtask

    task automatic test_error_hold();
        iREN = 0; dREN = 1; dWEN = 0; daddr = 32'h700; ramstate = 2'd0;
        #1;
        tick();
        for (int k = 0; k < 5; k++) begin
            ramstate = 2'd3;
            #1;
            n_cmp++;
            if (dwait !== 1'b1 || ramREN !== 1'b1 || ramaddr !== 32'h700) begin
                n_bad++;
                $display("FAIL error_hold: got dwait=%b ren=%b addr=%h want 1 1 700",
                         dwait, ramREN, ramaddr);
            end
            tick();
        end
        ramstate = 2'd2;
        #1;
        n_cmp++;
        if (dwait !== 1'b0) begin
            n_bad++;
            $display("FAIL error_recover: dwait got %b want 0", dwait);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_mid();
        iREN = 1; iaddr = 32'h800; dREN = 0; dWEN = 0; ramstate = 2'd1;
        #1;
        tick();
        n_cmp++;
        if (ramREN !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre: ren got %b want 1", ramREN);
        end
        ramstate = 2'd2;
        #1;
        nRST = 0;
        #1;
        m_own = M_IDLE; m_cnt = 0;
        n_cmp++;
        if ({ramREN, iwait, dwait} !== 3'b011) begin
            n_bad++;
            $display("FAIL rstmid_async: got %b want 011", {ramREN, iwait, dwait});
        end
        @(posedge CLK); #1;
        nRST = 1; ramstate = 2'd0;
        #1;
        n_cmp++;
        if (ramREN !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_idle: ren got %b want 0", ramREN);
        end
        tick();
        n_cmp++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h800) begin
            n_bad++;
            $display("FAIL rstmid_rearb: got ren=%b addr=%h want 1 800",
                     ramREN, ramaddr);
        end
        drain();
    endtask

    task automatic test_random();
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr;
        for (int k = 0; k < 400; k++) begin
            iREN = ($urandom_range(0, 9) < 6);
            dREN = ($urandom_range(0, 9) < 4);
            dWEN = ($urandom_range(0, 9) < 3);
            iaddr = $urandom; daddr = $urandom;
            dstore = $urandom; ramload = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            #1;
            e_ren = 0; e_wen = 0; e_addr = iaddr;
            if (m_own == M_I) begin
                e_ren = iREN;
            end else if (m_own == M_D) begin
                e_wen = dWEN;
                e_ren = dREN & ~dWEN;
                e_addr = daddr;
            end
            e_iw = !(m_own == M_I && ramstate == 2'd2);
            e_dw = !(m_own == M_D && ramstate == 2'd2);
            n_cmp++;
            if ({ramREN, ramWEN, iwait, dwait} !== {e_ren, e_wen, e_iw, e_dw}) begin
                n_bad++;
                $display("FAIL rand_ctl: cycle %0d got %b want %b", k,
                         {ramREN, ramWEN, iwait, dwait}, {e_ren, e_wen, e_iw, e_dw});
            end
            n_cmp++;
            if (ramaddr !== e_addr) begin
                n_bad++;
                $display("FAIL rand_addr: cycle %0d got %h want %h", k, ramaddr, e_addr);
            end
            n_cmp++;
            if ({ramstore, iload, dload} !== {dstore, ramload, ramload}) begin
                n_bad++;
                $display("FAIL rand_data: cycle %0d got %h %h %h", k,
                         ramstore, iload, dload);
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_simultaneous();
        test_back_to_back();
        test_starvation();
        test_error_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
